scan_chain_loader: RTL and testbench

- Programs the memory bank's serial scan chain (31 memory bytes, then the 1-bit button register, then the 7-bit LED register; 256 bits total) from a byte-wide valid/ready stream.
- Sits directly upstream of the memory bank and drives its scan_enable and scan_in pins.
- Holds the processor in halt while loading and pulses done when the full chain has been shifted.
- Optionally captures the bank's scan_out so the previous chain contents are streamed back out as bytes.

---
 rtl/scan_chain_loader_pkg.sv | 16 +
 rtl/scan_chain_loader_serializer.sv | 72 +++++++
 rtl/scan_chain_loader.sv | 167 ++++++++++++++++
 tb/tb_scan_chain_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_loader_pkg.sv
// Shared definitions for the scan-chain loader: FSM encoding and default chain geometry.
package scan_chain_loader_pkg;

  localparam int MEM_SIZE       = 31;
  localparam int DATA_WIDTH_DEF = 8;
  // 31 memory bytes, then the button bit, then the 7-bit LED register
  localparam int CHAIN_LEN_DEF  = (MEM_SIZE * DATA_WIDTH_DEF) + 1 + 7;
  localparam int CNT_WIDTH_DEF  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/scan_chain_loader_serializer.sv
// Byte-to-bit serializer: holds one byte and presents it MSB first, one bit per cycle,
// accepting the next byte while the last bit is leaving so the bit stream has no gaps.
module scan_byte_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  enable_i,
  input  logic                  block_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  bit_valid_o,
  output logic                  bit_o
);

  localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  full_q, full_d;
  logic                  last_bit;
  logic                  accept;

  assign last_bit    = full_q && (idx_q == LAST_IDX);
  assign in_ready_o  = enable_i && !block_i && (!full_q || last_bit);
  assign accept      = in_ready_o && in_valid_i;
  assign bit_valid_o = full_q;
  assign bit_o       = byte_q[DATA_WIDTH-1];

  // The byte shifts left so the outgoing bit is always the register MSB; an emptied
  // buffer is all zeros, which keeps the serial data line low while idle.
  always_comb begin
    byte_d = byte_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (full_q) begin
      byte_d = byte_q << 1;
      if (last_bit) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (accept) begin
      byte_d = in_data_i;
      idx_d  = '0;
      full_d = 1'b1;
    end
    if (flush_i) begin
      byte_d = '0;
      idx_d  = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Loads the memory bank scan chain from a byte stream while holding the CPU in halt.
// Define SCAN_LOADER_READBACK_EN to stream the previous chain contents back out on rb_data_o.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  scan_enable_o,
  output logic                  scan_in_o,
  input  logic                  scan_out_i,
  output logic                  halt_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  output logic                  rb_valid_o
);

  loader_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] bitcnt_q, bitcnt_d;
  logic                 ser_flush;
  logic                 ser_enable;
  logic                 ser_block;
  logic                 bit_valid;
  logic                 bit_val;
  logic                 last_shift;

  scan_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (ser_flush),
    .enable_i    (ser_enable),
    .block_i     (ser_block),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .bit_valid_o (bit_valid),
    .bit_o       (bit_val)
  );

  assign scan_enable_o = bit_valid;
  assign scan_in_o     = bit_val;
  assign last_shift    = bit_valid && (bitcnt_q == CNT_WIDTH'(CHAIN_LEN - 1));

  // The serializer is held empty outside LOAD, so scan_enable can only rise during a load;
  // the final shift blocks intake so surplus bytes stay with the producer.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    halt_o     = 1'b0;
    done_o     = 1'b0;
    ser_flush  = 1'b0;
    ser_enable = 1'b0;
    ser_block  = 1'b0;
    case (state_q)
      IDLE: begin
        ser_flush = 1'b1;
        if (start_i) begin
          state_d  = LOAD;
          bitcnt_d = '0;
        end
      end
      LOAD: begin
        halt_o     = 1'b1;
        ser_enable = 1'b1;
        if (abort_i) begin
          state_d   = IDLE;
          ser_flush = 1'b1;
          ser_block = 1'b1;
        end else begin
          if (bit_valid) begin
            bitcnt_d = bitcnt_q + CNT_WIDTH'(1);
          end
          if (last_shift) begin
            ser_block = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        halt_o    = 1'b1;
        done_o    = 1'b1;
        ser_flush = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        ser_flush = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
    end
  end

`ifdef SCAN_LOADER_READBACK_EN
  localparam int               RB_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [RB_IDX_W-1:0] RB_LAST = RB_IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] rb_shift_q, rb_shift_d;
  logic [DATA_WIDTH-1:0] rb_data_q, rb_data_d;
  logic [RB_IDX_W-1:0]   rb_cnt_q, rb_cnt_d;
  logic                  rb_valid_q, rb_valid_d;

  // scan_out is sampled on the same edge that shifts the chain, so the bit nearest the
  // output is captured first and bytes come back in the order they were originally loaded.
  always_comb begin
    rb_shift_d = rb_shift_q;
    rb_data_d  = rb_data_q;
    rb_cnt_d   = rb_cnt_q;
    rb_valid_d = 1'b0;
    if ((state_q == IDLE) && start_i) begin
      rb_shift_d = '0;
      rb_cnt_d   = '0;
    end else if ((state_q == LOAD) && bit_valid) begin
      rb_shift_d = (rb_shift_q << 1) | DATA_WIDTH'(scan_out_i);
      if (rb_cnt_q == RB_LAST) begin
        rb_cnt_d   = '0;
        rb_data_d  = rb_shift_d;
        rb_valid_d = 1'b1;
      end else begin
        rb_cnt_d = rb_cnt_q + RB_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_shift_q <= '0;
      rb_data_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_data_q  <= rb_data_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = rb_valid_q;
`else
  logic unused_scan_out;

  assign unused_scan_out = scan_out_i;
  assign rb_data_o       = '0;
  assign rb_valid_o      = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Scoreboard bench for scan_chain_loader: a driver queues expected scan bits, done events
// and readback bytes; a negedge monitor compares them against a model of the memory bank.
module tb_scan_chain_loader;

  localparam int CHAIN_LEN = 256;
  localparam int DW        = 8;
  localparam int LIMIT     = 1000;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  logic          clk_i      = 1'b0;
  logic          rst_ni     = 1'b0;
  logic          start_i    = 1'b0;
  logic          abort_i    = 1'b0;
  logic [DW-1:0] in_data_i  = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          scan_enable_o;
  logic          scan_in_o;
  logic          scan_out_i;
  logic          halt_o;
  logic          done_o;
  logic [DW-1:0] rb_data_o;
  logic          rb_valid_o;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic [DW-1:0]        img [0:32];

  logic    bitQ [$];
  int      doneQ [$];
  logic [DW-1:0] rbQ [$];
  chk_t    chkQ [$];

  int vectors      = 0;
  int miscompares  = 0;
  int cycle        = 0;
  int shiftCnt     = 0;
  int idleCnt      = 0;
  int lastShiftCyc = 0;
  int idleReadyBad = 0;
  int rbBad        = 0;
  int sent;

  logic          expBit;
  int            expShifts;
  logic [DW-1:0] expRb;
  chk_t          chk;

  scan_chain_loader dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .in_data_i     (in_data_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .scan_enable_o (scan_enable_o),
    .scan_in_o     (scan_in_o),
    .scan_out_i    (scan_out_i),
    .halt_o        (halt_o),
    .done_o        (done_o),
    .rb_data_o     (rb_data_o),
    .rb_valid_o    (rb_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory-bank stand-in: first bit shifted ends up at the scan_out end.
  assign scan_out_i = chain[CHAIN_LEN-1];
  always @(posedge clk_i) begin
    if (scan_enable_o) chain <= {chain[CHAIN_LEN-2:0], scan_in_o};
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic post(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chkQ.push_back(c);
  endtask

  function automatic int outs();
    return int'({in_ready_o, scan_enable_o, scan_in_o, halt_o, done_o, rb_valid_o, rb_data_o});
  endfunction

  task automatic setImage(input logic [DW-1:0] xorv);
    for (int k = 0; k < 33; k++) img[k] = DW'(k) ^ xorv;
  endtask

  task automatic checkChain(input string name);
    int bad = 0;
    logic [DW-1:0] got;
    for (int k = 0; k < 32; k++) begin
      got = chain[CHAIN_LEN-1-DW*k -: DW];
      if (got != img[k]) bad++;
    end
    post(name, bad, 0);
  endtask

  // mode 0: run to completion; 1: abort once trigAt shifts are done; 2: async reset instead
  task automatic applyStimulus(input int nBytes, input int gap, input int mode,
                               input int trigAt, output int nSent);
    int waitCnt = 0;
    int budget  = 0;
    logic [DW-1:0] b;
    nSent   = 0;
    start_i = 1'b1;
    if (mode == 0) doneQ.push_back(CHAIN_LEN);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (halt_o && budget < LIMIT) begin
      if (mode != 0 && shiftCnt >= trigAt) begin
        in_valid_i = 1'b0;
        if (mode == 1) abort_i = 1'b1;
        else rst_ni = 1'b0;
        break;
      end
      if (waitCnt > 0) begin
        in_valid_i = 1'b0;
        waitCnt--;
      end else if (nSent < nBytes) begin
        in_valid_i = 1'b1;
        in_data_i  = img[nSent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (in_valid_i && in_ready_o) begin
        b = img[nSent];
        for (int i = DW - 1; i >= 0; i--) bitQ.push_back(b[i]);
        nSent++;
        waitCnt = gap;
      end
      @(posedge clk_i); #1;
      budget++;
    end
    in_valid_i = 1'b0;
    if (budget >= LIMIT) post("load timeout", budget, 0);
  endtask

  always @(negedge clk_i) begin
    cycle <= cycle + 1;
    if (start_i && !halt_o) begin
      shiftCnt <= 0;
      idleCnt  <= 0;
    end else if (scan_enable_o) begin
      shiftCnt     <= shiftCnt + 1;
      lastShiftCyc <= cycle;
      if (bitQ.size() == 0) begin
        checkOutput("unexpected shift", 1, 0);
      end else begin
        expBit = bitQ.pop_front();
        checkOutput("scan_in bit", int'(scan_in_o), int'(expBit));
      end
    end else if (halt_o && !done_o) begin
      idleCnt <= idleCnt + 1;
    end
    if (done_o) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        expShifts = doneQ.pop_front();
        checkOutput("shifts at done", shiftCnt, expShifts);
        checkOutput("done latency", cycle - lastShiftCyc, 1);
      end
    end
    if (in_ready_o && !halt_o) idleReadyBad <= idleReadyBad + 1;
`ifdef SCAN_LOADER_READBACK_EN
    if (rb_valid_o && rbQ.size() > 0) begin
      expRb = rbQ.pop_front();
      checkOutput("readback byte", int'(rb_data_o), int'(expRb));
    end
`else
    if (rb_valid_o || rb_data_o != '0) rbBad <= rbBad + 1;
`endif
    while (chkQ.size() > 0) begin
      chk = chkQ.pop_front();
      checkOutput(chk.name, chk.act, chk.exp);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    setImage(8'h00);
    repeat (3) @(posedge clk_i);
    #1;
    post("outputs in reset", outs(), 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    post("outputs after reset", outs(), 0);

    // gap-free full load of 0x00..0x1F
    applyStimulus(32, 0, 0, 0, sent);
    post("full load bytes", sent, 32);
    post("full load idle cycles", idleCnt, 1);
    checkChain("full load chain");
    post("mem cell 5", int'(chain[215:208]), 5);

    // producer leaves 10 idle cycles after each accepted byte
    setImage(8'hA5);
    applyStimulus(32, 10, 0, 0, sent);
    post("gap load bytes", sent, 32);
    post("gap load idle cycles", idleCnt, 94);
    checkChain("gap load chain");

    // abort after 100 shifts, then a clean reload
    setImage(8'h3C);
    applyStimulus(32, 0, 1, 100, sent);
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    bitQ.delete();
    post("abort shift count", shiftCnt, 101);
    post("abort scan_enable", int'(scan_enable_o), 0);
    post("abort halt", int'(halt_o), 0);
    applyStimulus(32, 0, 0, 0, sent);
    post("reload bytes", sent, 32);
    checkChain("reload chain");

    // asynchronous reset while bit 3 of the second byte is due
    applyStimulus(32, 0, 2, 11, sent);
    #1;
    post("outputs in mid-load reset", outs(), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    bitQ.delete();
    @(posedge clk_i); #1;
    post("outputs after mid-load reset", outs(), 0);

    // 33 bytes offered, only 32 may be taken
    setImage(8'h5A);
    applyStimulus(33, 0, 0, 0, sent);
    post("surplus bytes accepted", sent, 32);
    checkChain("surplus chain");

`ifdef SCAN_LOADER_READBACK_EN
    setImage(8'h00);
    applyStimulus(32, 0, 0, 0, sent);
    for (int k = 0; k < 32; k++) rbQ.push_back(DW'(k));
    setImage(8'hC3);
    applyStimulus(32, 0, 0, 0, sent);
    checkChain("readback pass chain");
`endif

    repeat (2) @(posedge clk_i);
    #1;
    post("done events outstanding", doneQ.size(), 0);
    post("scan bits outstanding", bitQ.size(), 0);
    post("in_ready high outside load", idleReadyBad, 0);
`ifdef SCAN_LOADER_READBACK_EN
    post("readback bytes outstanding", rbQ.size(), 0);
`else
    post("readback tied off", rbBad, 0);
`endif
    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
